imem_boot_loader: RTL and testbench

- Sequences and owns the 64K x 16 instruction memory. Shares it between CPU instruction fetch and a byte-serial program loader.
- After a `set` pulse it stalls the CPU and takes bytes over a valid/ready handshake. It packs byte pairs into 16-bit instruction words, writes them from address 0 upward, then returns the memory to fetch.
- Sits between the PC/fetch stage and the instruction memory array. It replaces hard-coded program contents with runtime loading.

---
 rtl/imem_boot_loader.sv | 165 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Instruction-memory owner: passes CPU fetch through when idle, otherwise packs loader bytes into words.
// Optional macro IMEM_BOOT_CHECKSUM_EN adds a running 16-bit sum of written words on port `checksum`.
module imem_boot_loader #(
  parameter int ADDR_W    = 16,
  parameter int INST_W    = 16,
  parameter int MAX_WORDS = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [INST_W-1:0] cpu_inst,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [INST_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              busy,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_cnt
`ifdef IMEM_BOOT_CHECKSUM_EN
  ,
  output logic [INST_W-1:0] checksum
`endif
);

  typedef enum logic [2:0] {IDLE, LO, HI, WR, DONE} state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(MAX_WORDS - 1);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   ptr_reg, ptr_next;
  logic [ADDR_W:0]     cnt_reg, cnt_next;
  logic [7:0]          lo_reg, lo_next;
  logic [7:0]          hi_reg, hi_next;
  logic                last_reg, last_next;
  logic                err_reg, err_next;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [INST_W-1:0]   sum_reg, sum_next;
`endif

  assign mem_wdata = INST_W'({hi_reg, lo_reg});
  assign load_err  = err_reg;
  assign word_cnt  = cnt_reg;
`ifdef IMEM_BOOT_CHECKSUM_EN
  assign checksum  = sum_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      lo_reg    <= '0;
      hi_reg    <= '0;
      last_reg  <= 1'b0;
      err_reg   <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      lo_reg    <= lo_next;
      hi_reg    <= hi_next;
      last_reg  <= last_next;
      err_reg   <= err_next;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum_reg   <= sum_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    lo_next    = lo_reg;
    hi_next    = hi_reg;
    last_next  = last_reg;
    err_next   = err_reg;
`ifdef IMEM_BOOT_CHECKSUM_EN
    sum_next   = sum_reg;
`endif
    ld_ready   = 1'b0;
    cpu_stall  = 1'b1;
    cpu_inst   = '0;
    mem_addr   = ptr_reg;
    mem_we     = 1'b0;
    busy       = 1'b0;
    load_done  = 1'b0;

    case (state_reg)
      IDLE: begin
        cpu_stall = 1'b0;
        cpu_inst  = mem_rdata;
        mem_addr  = cpu_addr;
        if (set) begin
          state_next = LO;
          ptr_next   = '0;
          cnt_next   = '0;
          err_next   = 1'b0;
          last_next  = 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
          sum_next   = '0;
`endif
        end
      end
      LO: begin
        busy     = 1'b1;
        ld_ready = 1'b1;
        if (ld_valid) begin
          lo_next = ld_byte;
          if (ld_last) begin
            // Odd byte count: final word is zero-padded in the high byte.
            hi_next    = 8'h00;
            last_next  = 1'b1;
            state_next = WR;
          end else begin
            state_next = HI;
          end
        end
      end
      HI: begin
        busy     = 1'b1;
        ld_ready = 1'b1;
        if (ld_valid) begin
          hi_next    = ld_byte;
          last_next  = ld_last;
          state_next = WR;
        end
      end
      WR: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        ptr_next = ptr_reg + ADDR_W'(1);
        cnt_next = cnt_reg + (ADDR_W+1)'(1);
`ifdef IMEM_BOOT_CHECKSUM_EN
        sum_next = sum_reg + mem_wdata;
`endif
        if (last_reg) begin
          state_next = DONE;
        end else if ({1'b0, ptr_reg} == LAST_IDX) begin
          // Memory full before the loader signalled its last byte.
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          state_next = LO;
        end
      end
      DONE: begin
        load_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: stimulus queues expected writes/completions, a monitor checks them.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        set = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = 8'h00;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic [15:0] cpu_addr = 16'h0000;
  logic [15:0] cpu_inst;
  logic        cpu_stall;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        load_done;
  logic        load_err;
  logic [16:0] word_cnt;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  imem_boot_loader #(.ADDR_W(16), .INST_W(16), .MAX_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .set(set), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_last(ld_last), .ld_ready(ld_ready), .cpu_addr(cpu_addr), .cpu_inst(cpu_inst),
    .cpu_stall(cpu_stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy), .load_done(load_done), .load_err(load_err),
    .word_cnt(word_cnt)
`ifdef IMEM_BOOT_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] tbmem [0:255];
  assign mem_rdata = tbmem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) tbmem[mem_addr[7:0]] <= mem_wdata;

  int n_checks = 0;
  int n_pass = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endfunction

  typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
  typedef struct { logic [16:0] cnt; logic err; } done_t;
  wr_t   wr_q[$];
  done_t done_q[$];
  wr_t   mon_w;
  done_t mon_d;

  // Monitor: pops an expectation whenever the DUT presents a write or completion.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        if (wr_q.size() == 0) check("unexpected_write", 32'(mem_we), 32'd0);
        else begin
          mon_w = wr_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(mon_w.addr));
          check("wr_data", 32'(mem_wdata), 32'(mon_w.data));
          $display("write addr=%h data=%h", mem_addr, mem_wdata);
        end
      end
      if (load_done) begin
        if (done_q.size() == 0) check("unexpected_done", 32'(load_done), 32'd0);
        else begin
          mon_d = done_q.pop_front();
          check("done_word_cnt", 32'(word_cnt), 32'(mon_d.cnt));
          check("done_load_err", 32'(load_err), 32'(mon_d.err));
          check("done_stall", 32'(cpu_stall), 32'd1);
          check("done_busy", 32'(busy), 32'd0);
          $display("load_done word_cnt=%0d load_err=%0d", word_cnt, load_err);
        end
      end
      if (busy) begin
        check("busy_stall", 32'(cpu_stall), 32'd1);
        check("busy_nop", 32'(cpu_inst), 32'd0);
      end
    end
  end

  // Called right after a falling edge; returns on a falling edge.
  task automatic send(input logic [7:0] b, input logic last, input int budget, output bit ok);
    ok = 1'b0;
    ld_valid = 1'b1; ld_byte = b; ld_last = last;
    for (int i = 0; i < budget && !ok; i++) begin
      if (ld_ready) ok = 1'b1;
      @(negedge clk);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    $display("byte %h last=%0d accepted=%0d", b, last, ok);
  endtask

  task automatic send_ok(input logic [7:0] b, input logic last);
    bit ok;
    send(b, last, 10, ok);
    check("byte_accepted", 32'(ok), 32'd1);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_set();
    set = 1'b1;
    @(negedge clk);
    set = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || load_done) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_stall", 32'(cpu_stall), 32'd0);
  endtask

  task automatic push_w(input logic [15:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic push_d(input logic [16:0] c, input logic e);
    done_t d;
    d.cnt = c; d.err = e;
    done_q.push_back(d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    for (int i = 0; i < 256; i++) tbmem[i] = 16'hDEAD;
    tbmem[5] = 16'h9005;

    // Reset state and pass-through fetch
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_ready", 32'(ld_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    cpu_addr = 16'd5;
    #1;
    check("fetch_inst", 32'(cpu_inst), 32'h9005);
    check("fetch_addr", 32'(mem_addr), 32'd5);
    check("fetch_stall", 32'(cpu_stall), 32'd0);
    check("fetch_ready", 32'(ld_ready), 32'd0);
    @(negedge clk);

    // Two-word load, continuous valid
    push_w(16'd0, 16'h9205); push_w(16'd1, 16'h94FB); push_d(17'd2, 1'b0);
    pulse_set();
    send_ok(8'h05, 1'b0); send_ok(8'h92, 1'b0); send_ok(8'hFB, 1'b0); send_ok(8'h94, 1'b1);
    wait_idle();
    check("two_mem0", 32'(tbmem[0]), 32'h9205);
    check("two_mem1", 32'(tbmem[1]), 32'h94FB);
    gap(3);
    check("word_cnt_hold", 32'(word_cnt), 32'd2);
    cpu_addr = 16'd1;
    #1;
    check("fetch_loaded", 32'(cpu_inst), 32'h94FB);
    @(negedge clk);

    // Odd byte count pads the final high byte with zero
    push_w(16'd0, 16'h2211); push_w(16'd1, 16'h0033); push_d(17'd2, 1'b0);
    pulse_set();
    send_ok(8'h11, 1'b0); send_ok(8'h22, 1'b0); send_ok(8'h33, 1'b1);
    wait_idle();
    check("odd_mem1", 32'(tbmem[1]), 32'h0033);

    // Gaps in valid plus a stray set mid-load
    push_w(16'd0, 16'h9205); push_w(16'd1, 16'h94FB); push_d(17'd2, 1'b0);
    pulse_set();
    send_ok(8'h05, 1'b0);
    gap(2);
    pulse_set();
    send_ok(8'h92, 1'b0);
    gap(2);
    send_ok(8'hFB, 1'b0);
    send_ok(8'h94, 1'b1);
    wait_idle();
    check("gap_word_cnt", 32'(word_cnt), 32'd2);
    check("gap_err", 32'(load_err), 32'd0);
    check("gap_mem0", 32'(tbmem[0]), 32'h9205);
`ifdef IMEM_BOOT_CHECKSUM_EN
    check("checksum", 32'(checksum), 32'h2700);
`endif

    // Overflow: MAX_WORDS=4, ten bytes and no last marker
    push_w(16'd0, 16'h1110); push_w(16'd1, 16'h1312);
    push_w(16'd2, 16'h1514); push_w(16'd3, 16'h1716);
    push_d(17'd4, 1'b1);
    pulse_set();
    for (int i = 0; i < 8; i++) send_ok(8'(8'h10 + i), 1'b0);
    send(8'h18, 1'b0, 4, ok);
    check("ovf_byte9_rejected", 32'(ok), 32'd0);
    send(8'h19, 1'b0, 4, ok);
    check("ovf_byte10_rejected", 32'(ok), 32'd0);
    wait_idle();
    check("ovf_err_sticky", 32'(load_err), 32'd1);
    check("ovf_word_cnt", 32'(word_cnt), 32'd4);

    // Next set clears the error; then reset while in HI after one word
    push_w(16'd0, 16'hBBAA);
    pulse_set();
    check("set_clears_err", 32'(load_err), 32'd0);
    check("set_clears_cnt", 32'(word_cnt), 32'd0);
    send_ok(8'hAA, 1'b0); send_ok(8'hBB, 1'b0); send_ok(8'hCC, 1'b0);
    check("mid_word_cnt", 32'(word_cnt), 32'd1);
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_stall", 32'(cpu_stall), 32'd0);
    check("mrst_word_cnt", 32'(word_cnt), 32'd0);
    check("mrst_we", 32'(mem_we), 32'd0);
    check("mrst_ready", 32'(ld_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    gap(2);
    check("mrst_mem0_kept", 32'(tbmem[0]), 32'hBBAA);
    check("wr_queue_empty", 32'(wr_q.size()), 32'd0);
    check("done_queue_empty", 32'(done_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
